// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO between fetch and dispatch.
// Takes up to 4 packets per cycle from fetch and shows up to N of the oldest
// packets to dispatch. ibuff_open is the free-entry credit returned to fetch.
// Optional build macro IBUFF_OPEN_INCL_DEQ_EN: the credit also counts this
// cycle's dequeue, which adds a combinational path dispatch_num -> ibuff_open.

`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 16
`endif
`ifndef N
`define N 3
`endif

package inst_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] PC;
    logic [31:0] inst;
  } INST_PACKET;

  typedef enum logic [1:0] {
    NO_TASK = 2'd0,
    PREDICT = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;
endpackage

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int INST_BUFF_DEPTH = `INST_BUFF_DEPTH,
  parameter int N               = `N
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  BR_TASK                                 br_task,
  input  INST_PACKET [3:0]                       in_insts,
  input  logic [2:0]                             in_num_insts,
  input  logic [$clog2(N+1)-1:0]                 dispatch_num,
  output logic [$clog2(INST_BUFF_DEPTH+1)-1:0]   ibuff_open,
  output INST_PACKET [N-1:0]                     out_insts,
  output logic [$clog2(N+1)-1:0]                 out_num_insts
);

  localparam int PW = $clog2(INST_BUFF_DEPTH);
  localparam int CW = $clog2(INST_BUFF_DEPTH + 1);
  localparam int OW = $clog2(N + 1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  INST_PACKET    entries [INST_BUFF_DEPTH];

  logic [OW-1:0] deq;
  logic [2:0]    enq;
  logic [CW:0]   space;
  int            open_calc;

  // Show-ahead read side: present the oldest min(count, N) entries, zero the rest.
  always_comb begin
    out_num_insts = (count < CW'(N)) ? OW'(count) : OW'(N);
    for (int i = 0; i < N; i++) begin
      out_insts[i] = '0;
      if (i < int'(out_num_insts)) begin
        out_insts[i] = entries[head + PW'(i)];
      end
    end
  end

  // Clamp dispatch to what is shown, and fetch to the room left after that dequeue.
  always_comb begin
    deq   = (dispatch_num > out_num_insts) ? out_num_insts : dispatch_num;
    space = (CW+1)'(INST_BUFF_DEPTH) - {1'b0, count} + (CW+1)'(deq);
    enq   = in_num_insts;
    if (enq > 3'd4) begin
      enq = 3'd4;
    end
    if ((CW+1)'(enq) > space) begin
      enq = 3'(space);
    end
  end

  // Credit to fetch: packets already in flight from fetch are charged against the free space.
  always_comb begin
    open_calc = INST_BUFF_DEPTH - int'(count) - int'(in_num_insts);
`ifdef IBUFF_OPEN_INCL_DEQ_EN
    open_calc = open_calc + int'(deq);
    if (open_calc > INST_BUFF_DEPTH) begin
      open_calc = INST_BUFF_DEPTH;
    end
`endif
    if (open_calc < 0) begin
      open_calc = 0;
    end
    ibuff_open = CW'(open_calc);
  end

  // Pointer and occupancy bookkeeping; a squash empties the buffer and blocks this edge's traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (br_task == SQUASH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Entry storage; contents need no reset because only counted entries are ever shown.
  always_ff @(posedge clock) begin
    if (reset && (br_task != SQUASH)) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(enq)) begin
          entries[tail + PW'(i)] <= in_insts[i];
        end
      end
    end
  end

  // Dispatch must not take more than is presented (an empty buffer ignores dispatch_num).
  deq_within_presented: assert property (@(posedge clock) disable iff (!reset || br_task == SQUASH)
    (count == '0) || (dispatch_num <= out_num_insts));

  // Fetch must not deliver more packets than the buffer can accept this cycle.
  enq_within_credit: assert property (@(posedge clock) disable iff (!reset || br_task == SQUASH)
    (in_num_insts <= 3'd4) && ((CW+1)'(in_num_insts) <= space));

endmodule
